// File: rtl/symbol_pkg.sv
// symbol_pkg: shared types for the symbol rotation controller.
//   rot_state_t : 2-bit symbol form code, 0..3
//   pend_t      : pending manual rotation request
//   db_state_t  : button debounce FSM state
//   rot_step()  : apply one rotation request, wrapping modulo ROT_NUM
package symbol_pkg;

    localparam int ROT_NUM = 4;

    typedef logic [1:0] rot_state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_NEXT,
        PEND_PREV
    } pend_t;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_WAIT_PRESS,
        DB_PRESSED,
        DB_WAIT_RELEASE
    } db_state_t;

    // Two-bit arithmetic gives the 3 -> 0 and 0 -> 3 wrap for free.
    function automatic rot_state_t rot_step(rot_state_t r, pend_t dir);
        case (dir)
            PEND_NEXT: return r + 2'd1;
            PEND_PREV: return r - 2'd1;
            default:   return r;
        endcase
    endfunction

endpackage

// File: rtl/symbol_rot_ctrl_if.sv
// symbol_rot_ctrl_if: bundle between the board/VGA side and the rotation
// controller.
//   btn_next, btn_prev : raw asynchronous buttons, active-high
//   auto_en            : level, enables periodic +1 stepping
//   frame_start        : one-cycle frame-start pulse from VGA timing
//   rot_state          : registered symbol form, 0..3
//   rot_changed        : one-cycle pulse in the cycle rot_state takes a new value
//   pend_dbg           : pending manual request (observation only)
//   next_db_state,
//   prev_db_state      : debounce FSM states (observation only)
//
// There is no valid/ready pair here: frame_start and rot_changed are
// single-cycle strobes that are consumed in the cycle they are high and never
// back-pressured; rot_state is a level that is only meaningful to sample
// when rot_changed is high or at any later cycle.
interface symbol_rot_ctrl_if;
    import symbol_pkg::*;

    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic       frame_start;
    rot_state_t rot_state;
    logic       rot_changed;
    pend_t      pend_dbg;
    db_state_t  next_db_state;
    db_state_t  prev_db_state;

    modport master (
        output btn_next, btn_prev, auto_en, frame_start,
        input  rot_state, rot_changed, pend_dbg, next_db_state, prev_db_state
    );

    modport slave (
        input  btn_next, btn_prev, auto_en, frame_start,
        output rot_state, rot_changed, pend_dbg, next_db_state, prev_db_state
    );

endinterface

// File: rtl/symbol_rot_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a press/release debounce FSM.
//   clk, rst : clock, synchronous active-high reset
//   btn      : raw asynchronous button input
//   press    : one-cycle pulse on the WAIT_PRESS -> PRESSED transition
//   state    : current FSM state (observation)
// A level must be seen on DEBOUNCE_CYCLES consecutive synchronized cycles
// (counting the cycle that leaves the stable state) to be accepted.
module btn_debounce
    import symbol_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      btn,
    output logic      press,
    output db_state_t state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            sync_a;
    logic            level;
    db_state_t       state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            level  <= 1'b0;
            state  <= DB_IDLE;
            cnt    <= '0;
        end else begin
            sync_a <= btn;
            level  <= sync_a;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        case (state)
            DB_IDLE: begin
                // The first high cycle already counts as one stable cycle.
                if (level) begin
                    state_nxt = DB_WAIT_PRESS;
                    cnt_nxt   = CW'(1);
                end
            end
            DB_WAIT_PRESS: begin
                if (!level) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = DB_PRESSED;
                    cnt_nxt   = '0;
                    press     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DB_PRESSED: begin
                if (!level) begin
                    state_nxt = DB_WAIT_RELEASE;
                    cnt_nxt   = CW'(1);
                end
            end
            DB_WAIT_RELEASE: begin
                if (level) begin
                    state_nxt = DB_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/symbol_rot_ctrl.sv
// symbol_rot_ctrl: produces the 2-bit rot_state for the symbol renderer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : symbol_rot_ctrl_if.slave (buttons, auto_en, frame_start in;
//              rot_state, rot_changed and debug state out)
// Manual presses are latched into a pending request (last press wins, a
// simultaneous press of both buttons is dropped) and, like auto steps, are
// only committed on frame_start so a frame never shows two symbol forms.
module symbol_rot_ctrl
    import symbol_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int AUTO_PERIOD_FRAMES = 60
) (
    input logic                clk,
    input logic                rst,
    symbol_rot_ctrl_if.slave   bus
);

    localparam int FW = $clog2(AUTO_PERIOD_FRAMES) + 1;
    localparam logic [FW-1:0] FLAST = FW'(AUTO_PERIOD_FRAMES - 1);

    logic          press_next;
    logic          press_prev;
    db_state_t     next_db_state;
    db_state_t     prev_db_state;
    pend_t         pend;
    pend_t         pend_in;
    pend_t         apply_dir;
    logic [FW-1:0] fcnt;
    rot_state_t    rot;
    logic          changed;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_next),
        .press (press_next),
        .state (next_db_state)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_prev),
        .press (press_prev),
        .state (prev_db_state)
    );

    // pend_in folds in a press from this very cycle, so a press coinciding
    // with frame_start is applied at that frame instead of waiting a frame.
    always_comb begin
        pend_in   = pend;
        apply_dir = PEND_NONE;
        if (press_next && !press_prev) begin
            pend_in = PEND_NEXT;
        end else if (press_prev && !press_next) begin
            pend_in = PEND_PREV;
        end
        if (bus.frame_start) begin
            if (pend_in != PEND_NONE) begin
                apply_dir = pend_in;
            end else if (bus.auto_en && fcnt == FLAST) begin
                apply_dir = PEND_NEXT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rot     <= '0;
            changed <= 1'b0;
            pend    <= PEND_NONE;
            fcnt    <= '0;
        end else begin
            changed <= 1'b0;
            if (apply_dir != PEND_NONE) begin
                // Any apply, manual or auto, restarts the auto period.
                rot     <= rot_step(rot, apply_dir);
                changed <= 1'b1;
                pend    <= PEND_NONE;
                fcnt    <= '0;
            end else begin
                pend <= pend_in;
                if (!bus.auto_en) begin
                    fcnt <= '0;
                end else if (bus.frame_start) begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    assign bus.rot_state     = rot;
    assign bus.rot_changed   = changed;
    assign bus.pend_dbg      = pend;
    assign bus.next_db_state = next_db_state;
    assign bus.prev_db_state = prev_db_state;

endmodule
